ysyx_23060203_rd_arb: RTL
=========================

# ysyx_23060203_rd_arb

Parametrised N-requester AXI4 read-channel arbiter, the successor to the fixed three-port memory arbiter between IFU/LSU/MMU and the XBar. It grants one requester at a time, forwards its AR beat downstream, steers the R burst back until `rlast`, and then releases. Arbitration policy is selectable: fixed priority or round-robin.

## Interface
- `N`, 3: number of requester ports, legal range 2..8.
- `ARB_MODE`, 1: 0 = fixed priority (index 0 highest); 1 = round-robin.
- `IW`, `$clog2(N)`: grant index width (derived, do not override).

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `req_r[N]`  axi_if.in  per-requester AR/R channels (araddr 32, arlen 8, arsize 3, arburst 2, rdata 32, rresp 2, rlast).
- `mem_r`  axi_if.out  downstream AR/R channel toward the XBar.
- `busy`  out  1  high whenever state is not IDLE.
- `grant_id`  out  IW  index of the current or last granted requester.

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: the picker selects a winner among the asserted `req_r[i].arvalid`.
  - Fixed mode: lowest index wins.
  - RR mode: search starts at `ptr`; `ptr` updates to winner+1 (mod N) on the AR handshake.
- Without `YSYX_RDARB_ARREG_EN`:
  - IDLE drives `mem_r.ar*` combinationally from the winner.
  - If `mem_r.arready` is high in the same cycle, go to DATA; otherwise latch the winner and go to ADDR.
- ADDR: hold the grant with AR fields driven from the latched requester; go to DATA on `arready`.
- DATA: forward `rvalid/rdata/rresp/rlast` to the granted requester and pass its `rready` back. Return to IDLE on `rvalid & rready & rlast`.
- Non-granted requesters see `arready=0` and `rvalid=0` at all times.
- `rresp` (including SLVERR/DECERR) passes through unmodified. The arbiter never retries.
- Requester `arvalid` must stay asserted until its handshake. A requester dropping `arvalid` while in ADDR is a protocol violation; behaviour is undefined but must not corrupt other channels.
- Reset, including mid-burst: state goes to IDLE, `ptr=0`, `grant_id=0`, `busy=0`, and all `arready/rvalid` to requesters and `mem_r.arvalid/rready` are 0. Downstream is reset by the same system reset.

## Timing
- Arbiter AR latency: 0 cycles without the macro, 1 cycle with it.
- R path is purely combinational in DATA, with no added latency.
- After the last beat there is one mandatory IDLE cycle before the next grant, so back-to-back grants are 1 cycle apart minimum.
- Arbitration for a new grant uses only the `arvalid` values sampled in IDLE.
- Single outstanding transaction. `arlen` bursts up to 256 beats are supported.

## Configuration
- `YSYX_RDARB_ARREG_EN` defined:
  - In IDLE, the winner's AR fields are captured into a register and `arready` is pulsed to the winner in that same cycle.
  - Next cycle enters ADDR with registered `mem_r.arvalid`, which breaks the requester-to-downstream combinational path.
- Undefined: combinational AR pass-through as described above.

## Structure
- `ysyx_23060203_pkg` holds:
  - the `rdarb_state_t` enum (IDLE/ADDR/DATA);
  - the `RDARB_FIXED=0` and `RDARB_RR=1` constants.
- Sub-module `ysyx_23060203_rr_picker`: combinational rotating priority encoder.
  - Inputs: `req[N]`, `ptr[IW]`, `mode`.
  - Outputs: `gnt_vld`, `gnt_id`.

## Test plan
- N=3, RR, req0 only, `araddr=0x8000_0000`, `arlen=0`, downstream `arready` immediate → `mem_r.arvalid` in the same cycle (without macro), one R beat with `rdata=0xDEADBEEF` delivered to req0 only, `busy` drops the cycle after `rlast`.
- RR, req0/1/2 all asserted continuously, single-beat reads → grant order 0,1,2,0 and `grant_id` follows it. Fixed mode, same stimulus → 0,0,0 until req0 drops.
- Burst `arlen=3` on req1 with `rready` toggling 1,0,1,1,0,1 → four beats delivered in order, no beat lost or duplicated, req0/req2 `rvalid` stays 0 throughout.
- Downstream `arready` held low for 5 cycles while req2 waits and req0 rises → AR fields stay those of req2 and the grant does not switch.
- `rresp=2'b10` on a beat → delivered unmodified to the granted requester.
- `reset` asserted during beat 2 of 4 → all outputs at reset values asynchronously. After release, req0 is granted first in RR mode (`ptr=0`).

Source files
------------

// File: rtl/ysyx_23060203_rd_arb_pkg.sv
// ysyx_23060203 read arbiter shared types.
// Arbiter state encoding and arbitration-mode constants.
package ysyx_23060203_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rdarb_state_t;

  localparam int RDARB_FIXED = 0;
  localparam int RDARB_RR    = 1;

endpackage

// File: rtl/ysyx_23060203_rd_arb_if.sv
// AXI4 read-only channel bundle (AR + R).
// in: arbiter faces a requester; out: arbiter faces the XBar.
interface axi_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport in (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );

  modport out (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/ysyx_23060203_rr_picker.sv
// Rotating priority encoder for the read arbiter.
// mode=0: index 0 highest; mode=1: search starts at ptr.
module ysyx_23060203_rr_picker #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          mode,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_id
);

  // walk the search order backwards so the first hit wins
  always_comb begin
    int base;
    logic [IW-1:0] idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    base    = mode ? int'(ptr) : 0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((base + k) % N);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060203_rd_arb.sv
// N-port AXI4 read arbiter: one grant, AR forward, R steer.
// YSYX_RDARB_ARREG_EN: register the AR beat toward the XBar.
module ysyx_23060203_rd_arb
  import ysyx_23060203_pkg::*;
#(
  parameter int N        = 3,
  parameter int ARB_MODE = RDARB_RR,
  parameter int IW       = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset,
  axi_if.in             req_r [N],
  axi_if.out            mem_r,
  output logic          busy,
  output logic [IW-1:0] grant_id
);

  rdarb_state_t state_q, state_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] sel;
  logic [IW-1:0] pick_id;
  logic          pick_vld;
  logic          ar_pulse;
  logic          m_arvalid;
  logic          m_rready;
  logic          r_fwd;
  logic [N-1:0]  arv;
  logic [N-1:0]  rrdy;
  logic [31:0]   addr_a  [N];
  logic [7:0]    len_a   [N];
  logic [2:0]    size_a  [N];
  logic [1:0]    burst_a [N];

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
    return (x == IW'(N - 1)) ? '0 : x + IW'(1);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_req
    assign arv[g]     = req_r[g].arvalid;
    assign rrdy[g]    = req_r[g].rready;
    assign addr_a[g]  = req_r[g].araddr;
    assign len_a[g]   = req_r[g].arlen;
    assign size_a[g]  = req_r[g].arsize;
    assign burst_a[g] = req_r[g].arburst;
    assign req_r[g].arready =
      reset & ar_pulse & (sel == IW'(g));
    assign req_r[g].rvalid  =
      reset & r_fwd & mem_r.rvalid & (gid_q == IW'(g));
    assign req_r[g].rdata = mem_r.rdata;
    assign req_r[g].rresp = mem_r.rresp;
    assign req_r[g].rlast = mem_r.rlast;
  end

  ysyx_23060203_rr_picker #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req     (arv),
    .ptr     (ptr_q),
    .mode    (1'(ARB_MODE)),
    .gnt_vld (pick_vld),
    .gnt_id  (pick_id)
  );

`ifdef YSYX_RDARB_ARREG_EN
  logic        ar_cap;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
`endif

  // next state, grant bookkeeping and handshake steering
  always_comb begin
    state_d   = state_q;
    gid_d     = gid_q;
    ptr_d     = ptr_q;
    sel       = gid_q;
    ar_pulse  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    r_fwd     = 1'b0;
`ifdef YSYX_RDARB_ARREG_EN
    ar_cap    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          sel   = pick_id;
          gid_d = pick_id;
`ifdef YSYX_RDARB_ARREG_EN
          ar_pulse = 1'b1;
          ar_cap   = 1'b1;
          ptr_d    = nxt(pick_id);
          state_d  = ADDR;
`else
          m_arvalid = 1'b1;
          ar_pulse  = mem_r.arready;
          if (mem_r.arready) begin
            ptr_d   = nxt(pick_id);
            state_d = DATA;
          end else begin
            state_d = ADDR;
          end
`endif
        end
      end
      ADDR: begin
        m_arvalid = 1'b1;
`ifndef YSYX_RDARB_ARREG_EN
        ar_pulse = mem_r.arready;
        if (mem_r.arready) ptr_d = nxt(gid_q);
`endif
        if (mem_r.arready) state_d = DATA;
      end
      DATA: begin
        r_fwd    = 1'b1;
        m_rready = rrdy[gid_q];
        if (mem_r.rvalid && rrdy[gid_q] && mem_r.rlast)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, grant index and round-robin pointer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef YSYX_RDARB_ARREG_EN
  // capture the winner's AR beat; XBar sees it next cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else if (ar_cap) begin
      addr_q  <= addr_a[pick_id];
      len_q   <= len_a[pick_id];
      size_q  <= size_a[pick_id];
      burst_q <= burst_a[pick_id];
    end
  end

  assign mem_r.araddr  = addr_q;
  assign mem_r.arlen   = len_q;
  assign mem_r.arsize  = size_q;
  assign mem_r.arburst = burst_q;
`else
  assign mem_r.araddr  = addr_a[sel];
  assign mem_r.arlen   = len_a[sel];
  assign mem_r.arsize  = size_a[sel];
  assign mem_r.arburst = burst_a[sel];
`endif

  assign mem_r.arvalid = reset & m_arvalid;
  assign mem_r.rready  = reset & m_rready;
  assign busy          = (state_q != IDLE);
  assign grant_id      = gid_q;

endmodule
